// File: rtl/noc_node_port_pkg.sv
// rtl/noc_node_port_pkg.sv - packet type, FSM state encodings and byte helper for the node port
package noc_node_port_pkg;

    localparam int BYTES_PER_PKT = 4;

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [23:0] data;
    } pkt_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_B0,
        TX_B1,
        TX_B2,
        TX_B3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_R1,
        RX_R2,
        RX_R3,
        RX_HOLD
    } rx_state_t;

    // Byte idx of a packet on the wire; idx 0 is the MSB byte {src, dest}.
    function automatic logic [7:0] pkt_byte(input pkt_t p, input int idx);
        logic [31:0] w;
        w = p;
        return 8'(w >> (8 * (BYTES_PER_PKT - 1 - idx)));
    endfunction

endpackage

// File: rtl/noc_node_port_if.sv
// rtl/noc_node_port_if.sv - byte link between a node port and one router port
interface noc_node_port_if;
    logic       router_free;
    logic       to_router_put;
    logic [7:0] to_router_payload;
    logic       from_router_put;
    logic [7:0] from_router_payload;
    logic       node_free;
    logic [3:0] node_id;

    modport master (
        input  router_free, from_router_put, from_router_payload,
        output to_router_put, to_router_payload, node_free, node_id
    );

    modport slave (
        output router_free, from_router_put, from_router_payload,
        input  to_router_put, to_router_payload, node_free, node_id
    );
endinterface

// File: rtl/node_tx_fifo.sv
// rtl/node_tx_fifo.sv - synchronous packet FIFO with occupancy count, head visible on pop_data
module node_tx_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/noc_node_port.sv
// rtl/noc_node_port.sv - node endpoint: TX packet queue + byte serialiser, RX byte deserialiser
module noc_node_port
    import noc_node_port_pkg::*;
#(
    parameter logic [3:0] NODEID   = 4'd0,
    parameter int         TX_DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    noc_node_port_if.master           link,
    input  pkt_t                      pkt_in,
    input  logic                      pkt_in_valid,
    output logic                      pkt_in_ready,
    output pkt_t                      pkt_out,
    output logic                      pkt_out_valid,
    input  logic                      pkt_out_ready,
    output logic [$clog2(TX_DEPTH):0] tx_count,
    output logic                      proto_err
);
    tx_state_t   tx_state, tx_next;
    rx_state_t   rx_state, rx_next;
    pkt_t        fifo_head;
    logic        fifo_full, fifo_empty;
    logic        tx_start, tx_can_start;
    logic        tx_put;
    logic [7:0]  tx_byte;
    logic [23:0] tx_shift;
    logic        rx_err;
    logic        node_free_q;
    logic [23:0] rx_shift;

    node_tx_fifo #(.DEPTH(TX_DEPTH), .T(pkt_t)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (pkt_in_valid),
        .push_data (pkt_in),
        .pop       (tx_start),
        .pop_data  (fifo_head),
        .count     (tx_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pkt_in_ready           = !fifo_full;
    assign tx_can_start           = !fifo_empty && link.router_free;
    assign link.to_router_put     = tx_put;
    assign link.to_router_payload = tx_byte;
    assign link.node_free         = node_free_q;
    assign link.node_id           = NODEID;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
        end else begin
            tx_state <= tx_next;
            rx_state <= rx_next;
        end
    end

    // router_free only matters where a burst may begin: idle or the last byte.
    always_comb begin
        tx_next  = tx_state;
        tx_start = 1'b0;
        case (tx_state)
            TX_IDLE, TX_B3: begin
                tx_start = tx_can_start;
                tx_next  = tx_can_start ? TX_B0 : TX_IDLE;
            end
            TX_B0:   tx_next = TX_B1;
            TX_B1:   tx_next = TX_B2;
            TX_B2:   tx_next = TX_B3;
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_put   <= 1'b0;
            tx_byte  <= 8'h00;
            tx_shift <= 24'h0;
        end else begin
            tx_put <= (tx_next != TX_IDLE);
            if (tx_start) begin
                tx_byte  <= pkt_byte(fifo_head, 0);
                tx_shift <= fifo_head[23:0];
            end else if (tx_next != TX_IDLE) begin
                tx_byte  <= tx_shift[23:16];
                tx_shift <= {tx_shift[15:0], 8'h00};
            end else begin
                tx_byte <= 8'h00;
            end
        end
    end

    always_comb begin
        rx_next = rx_state;
        rx_err  = 1'b0;
        case (rx_state)
            RX_IDLE: if (link.from_router_put) rx_next = RX_R1;
            RX_R1: begin
                rx_err  = !link.from_router_put;
                rx_next = link.from_router_put ? RX_R2 : RX_IDLE;
            end
            RX_R2: begin
                rx_err  = !link.from_router_put;
                rx_next = link.from_router_put ? RX_R3 : RX_IDLE;
            end
            RX_R3: begin
                rx_err  = !link.from_router_put;
                rx_next = link.from_router_put ? RX_HOLD : RX_IDLE;
            end
            RX_HOLD: begin
                rx_err = link.from_router_put;
                if (pkt_out_ready) rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // A byte arriving in HOLD is dropped; pkt_out only changes on a completed burst.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_shift      <= 24'h0;
            pkt_out       <= '0;
            pkt_out_valid <= 1'b0;
            node_free_q   <= 1'b1;
            proto_err     <= 1'b0;
        end else begin
            node_free_q   <= (rx_next == RX_IDLE);
            pkt_out_valid <= (rx_next == RX_HOLD);
            if (rx_err) proto_err <= 1'b1;
            if (link.from_router_put) begin
                case (rx_state)
                    RX_IDLE:      rx_shift <= {16'h0000, link.from_router_payload};
                    RX_R1, RX_R2: rx_shift <= {rx_shift[15:0], link.from_router_payload};
                    RX_R3:        pkt_out  <= {rx_shift, link.from_router_payload};
                    default:      rx_shift <= rx_shift;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_noc_node_port.sv
// tb/tb_noc_node_port.sv - directed, table-driven bench for noc_node_port
module tb_noc_node_port;
    import noc_node_port_pkg::*;

    typedef struct {
        logic [31:0] pkt;
        logic [7:0]  eb [4];
    } tx_vec_t;

    typedef struct {
        logic [31:0] word;
        int          nbytes;
        int          hold;
        bit          exp_valid;
        logic [31:0] exp_pkt;
        bit          exp_err;
    } rx_vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    pkt_t        pkt_in;
    logic        pkt_in_valid;
    logic        pkt_in_ready;
    pkt_t        pkt_out;
    logic        pkt_out_valid;
    logic        pkt_out_ready;
    logic [2:0]  tx_count;
    logic        proto_err;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [7:0]  txq [$];
    int          txc [$];
    tx_vec_t     tv [8];
    rx_vec_t     rv [4];

    noc_node_port_if link();

    noc_node_port #(.NODEID(4'h5), .TX_DEPTH(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .link          (link.master),
        .pkt_in        (pkt_in),
        .pkt_in_valid  (pkt_in_valid),
        .pkt_in_ready  (pkt_in_ready),
        .pkt_out       (pkt_out),
        .pkt_out_valid (pkt_out_valid),
        .pkt_out_ready (pkt_out_ready),
        .tx_count      (tx_count),
        .proto_err     (proto_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (link.to_router_put === 1'b1) begin
            txq.push_back(link.to_router_payload);
            txc.push_back(cyc);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [7:0] qbyte(input int i);
        if (i < txq.size()) return txq[i];
        return 8'hxx;
    endfunction

    task automatic rx_send(input logic [31:0] word, input int n);
        for (int j = 0; j < n; j++) begin
            link.from_router_put     = 1'b1;
            link.from_router_payload = word[31-8*j -: 8];
            tick();
            if (j == 0) chk("rx node_free low after byte0", {31'd0, link.node_free}, 32'd0);
        end
        link.from_router_put     = 1'b0;
        link.from_router_payload = 8'h00;
    endtask

    initial begin
        tv[0].pkt = 32'h12A1B2C3; tv[0].eb = '{8'h12, 8'hA1, 8'hB2, 8'hC3};
        tv[1].pkt = 32'h01020304; tv[1].eb = '{8'h01, 8'h02, 8'h03, 8'h04};
        tv[2].pkt = 32'hA5000000; tv[2].eb = '{8'hA5, 8'h00, 8'h00, 8'h00};
        tv[3].pkt = 32'hFF80017E; tv[3].eb = '{8'hFF, 8'h80, 8'h01, 8'h7E};
        tv[4].pkt = 32'h3C00FF11; tv[4].eb = '{8'h3C, 8'h00, 8'hFF, 8'h11};
        tv[5].pkt = 32'h0BADF00D; tv[5].eb = '{8'h0B, 8'hAD, 8'hF0, 8'h0D};
        tv[6].pkt = 32'h80000001; tv[6].eb = '{8'h80, 8'h00, 8'h00, 8'h01};
        tv[7].pkt = 32'h7FFFFFFE; tv[7].eb = '{8'h7F, 8'hFF, 8'hFF, 8'hFE};

        rv[0] = '{32'h3400007F, 4, 5, 1'b1, 32'h3400007F, 1'b0};
        rv[1] = '{32'hDEADBEEF, 4, 0, 1'b1, 32'hDEADBEEF, 1'b0};
        rv[2] = '{32'hAABB0000, 2, 0, 1'b0, 32'h00000000, 1'b1};
        rv[3] = '{32'h5AA50FF0, 4, 0, 1'b1, 32'h5AA50FF0, 1'b1};

        reset_n                  = 1'b0;
        pkt_in                   = '0;
        pkt_in_valid             = 1'b0;
        pkt_out_ready            = 1'b0;
        link.router_free         = 1'b0;
        link.from_router_put     = 1'b0;
        link.from_router_payload = 8'h00;
        repeat (3) tick();

        chk("rst put",       {31'd0, link.to_router_put}, 32'd0);
        chk("rst payload",   {24'd0, link.to_router_payload}, 32'd0);
        chk("rst node_free", {31'd0, link.node_free}, 32'd1);
        chk("rst valid",     {31'd0, pkt_out_valid}, 32'd0);
        chk("rst pkt_out",   pkt_out, 32'd0);
        chk("rst tx_count",  {29'd0, tx_count}, 32'd0);
        chk("rst proto_err", {31'd0, proto_err}, 32'd0);
        chk("rst ready",     {31'd0, pkt_in_ready}, 32'd1);
        chk("node_id",       {28'd0, link.node_id}, 32'h5);
        reset_n = 1'b1;
        tick();

        // single packet, minimum latency
        link.router_free = 1'b1;
        pkt_in           = tv[0].pkt;
        pkt_in_valid     = 1'b1;
        tick();
        pkt_in_valid = 1'b0;
        chk("t1 count after push", {29'd0, tx_count}, 32'd1);
        chk("t1 put before burst", {31'd0, link.to_router_put}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t1 put cyc%0d", i), {31'd0, link.to_router_put}, 32'd1);
            chk($sformatf("t1 byte%0d", i), {24'd0, link.to_router_payload}, {24'd0, tv[0].eb[i]});
            if (i == 0) chk("t1 count after pop", {29'd0, tx_count}, 32'd0);
        end
        tick();
        chk("t1 put after burst", {31'd0, link.to_router_put}, 32'd0);

        // three back-to-back packets
        txq.delete();
        txc.delete();
        for (int p = 1; p <= 3; p++) begin
            pkt_in       = tv[p].pkt;
            pkt_in_valid = 1'b1;
            tick();
        end
        pkt_in_valid = 1'b0;
        repeat (16) tick();
        chk("t2 byte total", txq.size(), 32'd12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("t2 byte%0d", i), {24'd0, qbyte(i)}, {24'd0, tv[1 + i / 4].eb[i % 4]});
        if (txc.size() == 12) chk("t2 consecutive span", txc[11] - txc[0], 32'd11);
        else chk("t2 consecutive span", txc.size(), 32'd12);

        // fill FIFO with the router busy
        link.router_free = 1'b0;
        for (int p = 4; p <= 7; p++) begin
            pkt_in       = tv[p].pkt;
            pkt_in_valid = 1'b1;
            tick();
        end
        pkt_in_valid = 1'b0;
        chk("t2 full count", {29'd0, tx_count}, 32'd4);
        chk("t2 full ready", {31'd0, pkt_in_ready}, 32'd0);
        pkt_in       = 32'hFFFFFFFF;
        pkt_in_valid = 1'b1;
        tick();
        pkt_in_valid = 1'b0;
        chk("t2 push when full", {29'd0, tx_count}, 32'd4);

        // router not free: nothing moves; one free cycle gives one burst
        txq.delete();
        txc.delete();
        repeat (5) tick();
        chk("t3 no put while busy", txq.size(), 32'd0);
        chk("t3 count holds", {29'd0, tx_count}, 32'd4);
        link.router_free = 1'b1;
        tick();
        link.router_free = 1'b0;
        repeat (6) tick();
        chk("t3 one burst bytes", txq.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3 burst byte%0d", i), {24'd0, qbyte(i)}, {24'd0, tv[4].eb[i]});
        chk("t3 count after burst", {29'd0, tx_count}, 32'd3);
        link.router_free = 1'b1;
        repeat (16) tick();
        chk("t3 drain bytes", txq.size(), 32'd16);
        for (int i = 4; i < 16; i++)
            chk($sformatf("t3 drain byte%0d", i), {24'd0, qbyte(i)}, {24'd0, tv[4 + i / 4].eb[i % 4]});
        chk("t3 drained count", {29'd0, tx_count}, 32'd0);

        // RX vectors: full bursts, a dropped burst, recovery
        for (int v = 0; v < 4; v++) begin
            rx_send(rv[v].word, rv[v].nbytes);
            tick();
            chk($sformatf("rx%0d valid", v), {31'd0, pkt_out_valid}, {31'd0, rv[v].exp_valid});
            chk($sformatf("rx%0d proto_err", v), {31'd0, proto_err}, {31'd0, rv[v].exp_err});
            chk($sformatf("rx%0d node_free", v), {31'd0, link.node_free}, {31'd0, !rv[v].exp_valid});
            if (rv[v].exp_valid) begin
                chk($sformatf("rx%0d pkt", v), pkt_out, rv[v].exp_pkt);
                for (int h = 0; h < rv[v].hold; h++) begin
                    tick();
                    chk($sformatf("rx%0d hold%0d", v, h), {pkt_out_valid, link.node_free, 30'd0} ^ pkt_out,
                        {2'b10, 30'd0} ^ rv[v].exp_pkt);
                end
                pkt_out_ready = 1'b1;
                tick();
                pkt_out_ready = 1'b0;
                chk($sformatf("rx%0d consumed valid", v), {31'd0, pkt_out_valid}, 32'd0);
                chk($sformatf("rx%0d consumed node_free", v), {31'd0, link.node_free}, 32'd1);
            end
        end

        // reset in the middle of a TX burst (B2) and an RX burst (R2)
        link.router_free = 1'b1;
        pkt_in           = tv[1].pkt;
        pkt_in_valid     = 1'b1;
        tick();
        pkt_in           = tv[2].pkt;
        tick();
        pkt_in_valid             = 1'b0;
        link.from_router_put     = 1'b1;
        link.from_router_payload = 8'h55;
        tick();
        link.from_router_payload = 8'h66;
        tick();
        chk("t6 in B2 put", {31'd0, link.to_router_put}, 32'd1);
        chk("t6 in B2 byte", {24'd0, link.to_router_payload}, {24'd0, tv[1].eb[2]});
        reset_n = 1'b0;
        #1;
        chk("t6 rst put", {31'd0, link.to_router_put}, 32'd0);
        chk("t6 rst count", {29'd0, tx_count}, 32'd0);
        chk("t6 rst node_free", {31'd0, link.node_free}, 32'd1);
        chk("t6 rst proto_err", {31'd0, proto_err}, 32'd0);
        link.from_router_put     = 1'b0;
        link.from_router_payload = 8'h00;
        repeat (2) tick();
        reset_n = 1'b1;
        txq.delete();
        txc.delete();
        repeat (8) tick();
        chk("t6 nothing sent after reset", txq.size(), 32'd0);
        chk("t6 no packet delivered", {31'd0, pkt_out_valid}, 32'd0);
        chk("t6 node_free after reset", {31'd0, link.node_free}, 32'd1);

        // byte arriving while a packet is held
        rx_send(32'h11223344, 4);
        tick();
        chk("hold valid", {31'd0, pkt_out_valid}, 32'd1);
        link.from_router_put     = 1'b1;
        link.from_router_payload = 8'h99;
        tick();
        link.from_router_put     = 1'b0;
        tick();
        chk("hold err set", {31'd0, proto_err}, 32'd1);
        chk("hold pkt kept", pkt_out, 32'h11223344);
        chk("hold still valid", {31'd0, pkt_out_valid}, 32'd1);
        pkt_out_ready = 1'b1;
        tick();
        pkt_out_ready = 1'b0;
        chk("hold consumed", {31'd0, pkt_out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
